// File: rtl/rice_riscv_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rice_riscv_inst_encoder
// Brief    : Streaming RV32I/Zicsr/Zifencei encoder. Symbolic requests in,
//            32-bit instruction words out. Optional LI expansion is enabled
//            by defining RICE_RISCV_INST_ENCODER_LI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rice_riscv_inst_encoder #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [5:0]             i_req_op,
    input  logic [4:0]             i_req_rd,
    input  logic [4:0]             i_req_rs1,
    input  logic [4:0]             i_req_rs2,
    input  logic [31:0]            i_req_imm,
    output logic                   o_inst_valid,
    input  logic                   i_inst_ready,
    output logic [31:0]            o_inst,
    output logic                   o_inst_error,
    output logic                   o_inst_last,
    output logic [COUNT_WIDTH-1:0] o_inst_count
);

    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    localparam logic [3:0] c_fmt_ill   = 4'd0;
    localparam logic [3:0] c_fmt_r     = 4'd1;
    localparam logic [3:0] c_fmt_i     = 4'd2;
    localparam logic [3:0] c_fmt_s     = 4'd3;
    localparam logic [3:0] c_fmt_b     = 4'd4;
    localparam logic [3:0] c_fmt_u     = 4'd5;
    localparam logic [3:0] c_fmt_j     = 4'd6;
    localparam logic [3:0] c_fmt_sh    = 4'd7;
    localparam logic [3:0] c_fmt_csr   = 4'd8;
    localparam logic [3:0] c_fmt_fence = 4'd9;
    localparam logic [3:0] c_fmt_raw   = 4'd10;
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
    localparam logic [3:0] c_fmt_li    = 4'd11;
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_second = 1'b1;
`endif

    localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

    logic [3:0]  w_fmt;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [6:0]  w_opc;
    logic [31:0] w_raw;
    logic [31:0] w_word;
    logic        w_fail;
    logic        w_two;
    logic [31:0] w_load_word;
    logic        w_s12;
    logic        w_s13;
    logic        w_s21;
    logic        w_idle;
    logic        w_out_free;
    logic        w_accept;

    logic                   r_valid;
    logic [31:0]            r_inst;
    logic                   r_error;
    logic                   r_last;
    logic [COUNT_WIDTH-1:0] r_count;

`ifdef RICE_RISCV_INST_ENCODER_LI_EN
    logic [31:0] w_second;
    logic [19:0] w_li_hi;
    logic [0:0]  r_state;
    logic [31:0] r_pend;
`endif

    // Operation index -> format, funct3, funct7[5] and major opcode
    always_comb begin
        w_fmt = c_fmt_ill;
        w_f3  = 3'd0;
        w_alt = 1'b0;
        w_opc = 7'd0;
        w_raw = 32'h0;
        case (i_req_op)
            6'd0:  begin w_fmt = c_fmt_u; w_opc = c_opc_lui; end
            6'd1:  begin w_fmt = c_fmt_u; w_opc = c_opc_auipc; end
            6'd2:  begin w_fmt = c_fmt_j; w_opc = c_opc_jal; end
            6'd3:  begin w_fmt = c_fmt_i; w_opc = c_opc_jalr; end
            6'd4:  begin w_fmt = c_fmt_b; w_opc = c_opc_branch; w_f3 = 3'd0; end
            6'd5:  begin w_fmt = c_fmt_b; w_opc = c_opc_branch; w_f3 = 3'd1; end
            6'd6:  begin w_fmt = c_fmt_b; w_opc = c_opc_branch; w_f3 = 3'd4; end
            6'd7:  begin w_fmt = c_fmt_b; w_opc = c_opc_branch; w_f3 = 3'd5; end
            6'd8:  begin w_fmt = c_fmt_b; w_opc = c_opc_branch; w_f3 = 3'd6; end
            6'd9:  begin w_fmt = c_fmt_b; w_opc = c_opc_branch; w_f3 = 3'd7; end
            6'd10: begin w_fmt = c_fmt_i; w_opc = c_opc_load; w_f3 = 3'd0; end
            6'd11: begin w_fmt = c_fmt_i; w_opc = c_opc_load; w_f3 = 3'd1; end
            6'd12: begin w_fmt = c_fmt_i; w_opc = c_opc_load; w_f3 = 3'd2; end
            6'd13: begin w_fmt = c_fmt_i; w_opc = c_opc_load; w_f3 = 3'd4; end
            6'd14: begin w_fmt = c_fmt_i; w_opc = c_opc_load; w_f3 = 3'd5; end
            6'd15: begin w_fmt = c_fmt_s; w_opc = c_opc_store; w_f3 = 3'd0; end
            6'd16: begin w_fmt = c_fmt_s; w_opc = c_opc_store; w_f3 = 3'd1; end
            6'd17: begin w_fmt = c_fmt_s; w_opc = c_opc_store; w_f3 = 3'd2; end
            6'd18: begin w_fmt = c_fmt_i; w_opc = c_opc_op_imm; w_f3 = 3'd0; end
            6'd19: begin w_fmt = c_fmt_i; w_opc = c_opc_op_imm; w_f3 = 3'd2; end
            6'd20: begin w_fmt = c_fmt_i; w_opc = c_opc_op_imm; w_f3 = 3'd3; end
            6'd21: begin w_fmt = c_fmt_i; w_opc = c_opc_op_imm; w_f3 = 3'd4; end
            6'd22: begin w_fmt = c_fmt_i; w_opc = c_opc_op_imm; w_f3 = 3'd6; end
            6'd23: begin w_fmt = c_fmt_i; w_opc = c_opc_op_imm; w_f3 = 3'd7; end
            6'd24: begin w_fmt = c_fmt_sh; w_opc = c_opc_op_imm; w_f3 = 3'd1; end
            6'd25: begin w_fmt = c_fmt_sh; w_opc = c_opc_op_imm; w_f3 = 3'd5; end
            6'd26: begin w_fmt = c_fmt_sh; w_opc = c_opc_op_imm; w_f3 = 3'd5; w_alt = 1'b1; end
            6'd27: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd0; end
            6'd28: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd0; w_alt = 1'b1; end
            6'd29: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd1; end
            6'd30: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd2; end
            6'd31: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd3; end
            6'd32: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd4; end
            6'd33: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd5; end
            6'd34: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd5; w_alt = 1'b1; end
            6'd35: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd6; end
            6'd36: begin w_fmt = c_fmt_r; w_opc = c_opc_op; w_f3 = 3'd7; end
            6'd37: begin w_fmt = c_fmt_fence; w_opc = c_opc_misc_mem; end
            6'd38: begin w_fmt = c_fmt_raw; w_raw = 32'h0000100F; end
            6'd39: begin w_fmt = c_fmt_raw; w_raw = 32'h00000073; end
            6'd40: begin w_fmt = c_fmt_raw; w_raw = 32'h00100073; end
            6'd41: begin w_fmt = c_fmt_raw; w_raw = 32'h30200073; end
            6'd42: begin w_fmt = c_fmt_csr; w_opc = c_opc_system; w_f3 = 3'd1; end
            6'd43: begin w_fmt = c_fmt_csr; w_opc = c_opc_system; w_f3 = 3'd2; end
            6'd44: begin w_fmt = c_fmt_csr; w_opc = c_opc_system; w_f3 = 3'd3; end
            6'd45: begin w_fmt = c_fmt_csr; w_opc = c_opc_system; w_f3 = 3'd5; end
            6'd46: begin w_fmt = c_fmt_csr; w_opc = c_opc_system; w_f3 = 3'd6; end
            6'd47: begin w_fmt = c_fmt_csr; w_opc = c_opc_system; w_f3 = 3'd7; end
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
            6'd48: begin w_fmt = c_fmt_li; w_opc = c_opc_op_imm; end
`endif
            default: w_fmt = c_fmt_ill;
        endcase
    end

    // Sign-extension checks: every bit above the field's sign bit must match it
    assign w_s12 = (&i_req_imm[31:11]) | ~(|i_req_imm[31:11]);
    assign w_s13 = (&i_req_imm[31:12]) | ~(|i_req_imm[31:12]);
    assign w_s21 = (&i_req_imm[31:20]) | ~(|i_req_imm[31:20]);

`ifdef RICE_RISCV_INST_ENCODER_LI_EN
    // Rounds up the upper part when the low 12 bits sign-extend negative
    assign w_li_hi = i_req_imm[31:12] + {19'd0, i_req_imm[11]};
`endif

    always_comb begin
        w_word = 32'h0;
        w_fail = 1'b0;
        w_two  = 1'b0;
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
        w_second = 32'h0;
`endif
        case (w_fmt)
            c_fmt_r: w_word = {1'b0, w_alt, 5'd0, i_req_rs2, i_req_rs1, w_f3, i_req_rd, w_opc};
            c_fmt_i: begin
                w_word = {i_req_imm[11:0], i_req_rs1, w_f3, i_req_rd, w_opc};
                w_fail = ~w_s12;
            end
            c_fmt_s: begin
                w_word = {i_req_imm[11:5], i_req_rs2, i_req_rs1, w_f3, i_req_imm[4:0], w_opc};
                w_fail = ~w_s12;
            end
            c_fmt_b: begin
                w_word = {i_req_imm[12], i_req_imm[10:5], i_req_rs2, i_req_rs1, w_f3,
                          i_req_imm[4:1], i_req_imm[11], w_opc};
                w_fail = ~w_s13 | i_req_imm[0];
            end
            c_fmt_u: begin
                w_word = {i_req_imm[31:12], i_req_rd, w_opc};
                w_fail = |i_req_imm[11:0];
            end
            c_fmt_j: begin
                w_word = {i_req_imm[20], i_req_imm[10:1], i_req_imm[11], i_req_imm[19:12],
                          i_req_rd, w_opc};
                w_fail = ~w_s21 | i_req_imm[0];
            end
            c_fmt_sh: begin
                w_word = {1'b0, w_alt, 5'd0, i_req_imm[4:0], i_req_rs1, w_f3, i_req_rd, w_opc};
                w_fail = |i_req_imm[31:5];
            end
            c_fmt_csr: begin
                w_word = {i_req_imm[11:0], i_req_rs1, w_f3, i_req_rd, w_opc};
                w_fail = |i_req_imm[31:12];
            end
            c_fmt_fence: begin
                w_word = {4'd0, i_req_imm[7:4], i_req_imm[3:0], 5'd0, 3'd0, 5'd0, w_opc};
                w_fail = |i_req_imm[31:8];
            end
            c_fmt_raw: w_word = w_raw;
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
            c_fmt_li: begin
                if (w_s12) begin
                    w_word = {i_req_imm[11:0], 5'd0, 3'd0, i_req_rd, c_opc_op_imm};
                end else begin
                    w_word   = {w_li_hi, i_req_rd, c_opc_lui};
                    w_two    = |i_req_imm[11:0];
                    w_second = {i_req_imm[11:0], i_req_rd, 3'd0, i_req_rd, c_opc_op_imm};
                end
            end
`endif
            default: w_fail = 1'b1;
        endcase
    end

    assign w_load_word = w_fail ? 32'h0 : w_word;

`ifdef RICE_RISCV_INST_ENCODER_LI_EN
    assign w_idle = (r_state == c_st_idle);
`else
    assign w_idle = 1'b1;
`endif

    assign w_out_free  = ~r_valid | i_inst_ready;
    assign o_req_ready = w_idle & w_out_free & ~i_rst;
    assign w_accept    = i_req_valid & o_req_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_inst  <= 32'h0;
            r_error <= 1'b0;
            r_last  <= 1'b0;
            r_count <= '0;
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
            r_state <= c_st_idle;
            r_pend  <= 32'h0;
`endif
        end else begin
            if (r_valid && i_inst_ready) begin
                r_count <= r_count + c_count_one;
            end
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
            if (r_state == c_st_second) begin
                if (w_out_free) begin
                    r_valid <= 1'b1;
                    r_inst  <= r_pend;
                    r_error <= 1'b0;
                    r_last  <= 1'b1;
                    r_state <= c_st_idle;
                end
            end else
`endif
            if (w_accept) begin
                r_valid <= 1'b1;
                r_inst  <= w_load_word;
                r_error <= w_fail;
                r_last  <= ~w_two;
`ifdef RICE_RISCV_INST_ENCODER_LI_EN
                r_state <= w_two ? c_st_second : c_st_idle;
                r_pend  <= w_second;
`endif
            end else if (w_out_free) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_inst_valid = r_valid;
    assign o_inst       = r_inst;
    assign o_inst_error = r_error;
    assign o_inst_last  = r_last;
    assign o_inst_count = r_count;

endmodule
`default_nettype wire
